cart_backup_engine: RTL
=======================

Name: cart_backup_engine

Overview:
Sequencer on the host/SD side of the cartridge backup-RAM port. It streams battery RAM between the cart RAM dual-port backup interface (bk_*) and 512-byte SD sectors, in both directions:
- Load: SD sectors are written into cart RAM.
- Save: cart RAM is read out into SD sectors.

It sits between hps_io's sd_* sector interface and the cart's bk_* port, one sector per LBA. The number of sectors comes from ram_mask_file.

Parameters:
- LBA_W, 32, width of sd_lba.
- ACK_TIMEOUT, 24'hFFFFFF, clk_sys cycles allowed for sd_ack to rise after a request before the transfer aborts.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- bk_load  in  1  start load (level sampled; rising edge detected internally)
- bk_save  in  1  start save (rising edge detected internally)
- has_save  in  1  cart has battery RAM; commands are ignored when 0
- img_readonly  in  1  save image is read-only; save commands are ignored when 1
- ram_mask_file  in  8  last sector index of the transfer (sectors = mask+1)
- sd_lba  out  LBA_W  sector number requested
- sd_rd  out  1  sector read request (SD to engine)
- sd_wr  out  1  sector write request (engine to SD)
- sd_ack  in  1  host acknowledge; high for the whole sector transfer
- sd_buff_addr  in  8  word index within the sector (0..255)
- sd_buff_dout  in  16  sector word from the host (load)
- sd_buff_wr  in  1  strobe qualifying sd_buff_dout
- sd_buff_din  out  16  sector word to the host (save)
- bk_addr  out  17  cart RAM word address
- bk_wr  out  1  cart RAM word write
- bk_data  out  16  cart RAM write data
- bk_q  in  16  cart RAM read data (1-cycle dpram latency)
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when a transfer completes
- error  out  1  sticky; set on ack timeout, cleared at the start of the next command

Behaviour:
- Reset values: all outputs are 0. Reset asserted mid-transfer drops sd_rd, sd_wr and bk_wr immediately; no partial state survives.
- Command edges:
  - Rising edges of bk_load and bk_save are registered.
  - An edge is accepted only in IDLE, with has_save=1; save additionally requires img_readonly=0.
  - If load and save rise in the same cycle, load wins and save is dropped.
  - Edges that arrive while busy are dropped; they are not queued.
- States:
  - IDLE: on an accepted command, set dir (1=load), set sd_lba=0, clear error, set busy=1, go to REQ.
  - REQ: assert sd_rd (load) or sd_wr (save) and start the timeout counter. When sd_ack=1, deassert the request the same cycle and go to XFER. If the counter reaches ACK_TIMEOUT first, deassert the request, set error=1 and go to FIN.
  - XFER: stay while sd_ack=1. On sd_ack falling, go to NEXT.
  - NEXT: if sd_lba[7:0]==ram_mask_file, go to FIN; otherwise increment sd_lba and go to REQ.
  - FIN: pulse done for 1 cycle, set busy=0, go to IDLE.
- Address map:
  - bk_addr = {1'b0, sd_lba[7:0], sd_buff_addr}, registered one cycle after sd_buff_addr.
  - Upper sd_lba bits are always 0.
- Load path: while in XFER with dir=1, sd_ack=1 and sd_buff_wr=1, the next cycle carries bk_wr=1, bk_data=sd_buff_dout and bk_addr from the same cycle's sd_buff_addr. Word order is unchanged.
- Save path:
  - bk_wr is never asserted.
  - sd_buff_din = bk_q is valid 2 clk_sys cycles after sd_buff_addr changes: 1 cycle for the bk_addr register, 1 for the dpram.
  - sd_buff_wr is ignored.
- bk_wr is 0 in every state other than XFER.
- sd_buff_wr outside XFER, or with sd_ack=0, is ignored.
- ram_mask_file is latched at command accept; changes mid-transfer have no effect.
- ram_mask_file=0xFF gives 256 sectors (128 KB). sd_lba[7:0] must not wrap, because the NEXT compare ends the transfer first.

Test Plan:
- Load, mask=0x0F, host supplies word = {lba, addr}: exactly 16 sd_rd handshakes with sd_lba 0..15; 4096 bk_wr pulses; the word at bk_addr 0x0A37 is 0x0A37; done pulses once and busy falls the same cycle.
- Save, mask=0x03, cart RAM preloaded with addr^0x5A5A: 4 sd_wr handshakes; sd_buff_din equals bk_addr^0x5A5A two cycles after each sd_buff_addr change; bk_wr stays 0 throughout.
- bk_load and bk_save rise in the same cycle: only sd_rd is asserted. A bk_save edge during that load is ignored, giving no second transfer.
- Gating: has_save=0 with both edges, or img_readonly=1 with bk_save: busy stays 0 and no sd_rd/sd_wr. img_readonly=1 with bk_load: the load runs.
- ACK_TIMEOUT=16 with sd_ack held 0: the request drops after 16 cycles, error=1, done pulses, busy=0. A following good load clears error.
- reset_n low during sector 5 of a load: sd_rd, bk_wr and busy go 0 asynchronously. After release, a new bk_load edge restarts at sd_lba=0.

Source files
------------

// File: rtl/cart_backup_engine.sv
// Backup-RAM sequencer: streams cart battery RAM to/from 512-byte SD sectors,
// one sector per LBA, sectors 0..ram_mask_file.
module cart_backup_engine #(
    parameter int          LBA_W       = 32,
    parameter logic [23:0] ACK_TIMEOUT = 24'hFFFFFF
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             bk_load,
    input  logic             bk_save,
    input  logic             has_save,
    input  logic             img_readonly,
    input  logic [7:0]       ram_mask_file,
    output logic [LBA_W-1:0] sd_lba,
    output logic             sd_rd,
    output logic             sd_wr,
    input  logic             sd_ack,
    input  logic [7:0]       sd_buff_addr,
    input  logic [15:0]      sd_buff_dout,
    input  logic             sd_buff_wr,
    output logic [15:0]      sd_buff_din,
    output logic [16:0]      bk_addr,
    output logic             bk_wr,
    output logic [15:0]      bk_data,
    input  logic [15:0]      bk_q,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_NEXT, S_FIN} state_t;

    state_t      state, state_nxt;
    logic        load_q, save_q;
    logic        dir;
    logic        err_q;
    logic [7:0]  lba;
    logic [7:0]  mask;
    logic [23:0] tmo;
    logic        load_rise, save_rise, start_load, start_save, start;
    logic        tmo_hit, last_sector;

    always_comb begin
        load_rise   = bk_load & ~load_q;
        save_rise   = bk_save & ~save_q;
        start_load  = has_save & load_rise;
        // a simultaneous load edge wins; the save edge is simply lost
        start_save  = has_save & ~img_readonly & save_rise & ~load_rise;
        start       = (state == S_IDLE) & (start_load | start_save);
        tmo_hit     = (tmo == ACK_TIMEOUT - 24'd1);
        last_sector = (lba == mask);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_REQ;
            S_REQ: begin
                if (sd_ack)       state_nxt = S_XFER;
                else if (tmo_hit) state_nxt = S_FIN;
            end
            S_XFER: if (!sd_ack) state_nxt = S_NEXT;
            S_NEXT: state_nxt = last_sector ? S_FIN : S_REQ;
            S_FIN:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            load_q <= 1'b0;
            save_q <= 1'b0;
            dir    <= 1'b0;
            err_q  <= 1'b0;
            lba    <= 8'd0;
            mask   <= 8'd0;
            tmo    <= 24'd0;
        end else begin
            state  <= state_nxt;
            load_q <= bk_load;
            save_q <= bk_save;
            if (start) begin
                dir   <= start_load;
                lba   <= 8'd0;
                mask  <= ram_mask_file;
                err_q <= 1'b0;
            end
            if (state == S_REQ && !sd_ack && tmo_hit)
                err_q <= 1'b1;
            if (state == S_NEXT && !last_sector)
                lba <= lba + 8'd1;
            // counter is zero whenever REQ is entered from IDLE or NEXT
            tmo <= (state == S_REQ) ? tmo + 24'd1 : 24'd0;
        end
    end

    // bk_addr lags sd_buff_addr by one cycle; on save the dpram adds another
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bk_addr <= 17'd0;
            bk_wr   <= 1'b0;
            bk_data <= 16'd0;
        end else begin
            bk_addr <= {1'b0, lba, sd_buff_addr};
            bk_wr   <= (state == S_XFER) & dir & sd_ack & sd_buff_wr;
            if ((state == S_XFER) && dir && sd_ack && sd_buff_wr)
                bk_data <= sd_buff_dout;
        end
    end

    assign sd_rd       = (state == S_REQ) &  dir & ~sd_ack;
    assign sd_wr       = (state == S_REQ) & ~dir & ~sd_ack;
    assign busy        = (state == S_REQ) | (state == S_XFER) | (state == S_NEXT);
    assign done        = (state == S_FIN);
    assign error       = err_q;
    assign sd_buff_din = bk_q;
    assign sd_lba      = {{(LBA_W-8){1'b0}}, lba};

endmodule
